// File: rtl/divider_seq.sv
// Sequential unsigned divider by repeated subtraction (IDLE -> SUB -> FIN).
// Optional macro DIV_ABORT_EN: a start request during SUB restarts with the new operands.
module divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIVZ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             divz_q, divz_d;
    logic             accept;

`ifdef DIV_ABORT_EN
    assign accept = S && (state_q == IDLE || state_q == SUB);
`else
    assign accept = S && (state_q == IDLE);
`endif

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first, so no path through
        // the case below can leave a variable unassigned and infer a latch.
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        div_d   = div_q;
        divz_d  = divz_q;

        if (accept) begin
            r_d = A;
            if (B != '0) begin
                q_d     = '0;
                div_d   = B;
                divz_d  = 1'b0;
                state_d = SUB;
            end else begin
                // Divide by zero reports an all-ones quotient and skips iteration.
                q_d     = '1;
                divz_d  = 1'b1;
                state_d = FIN;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                SUB: begin
                    if (r_q >= div_q) begin
                        r_d = r_q - div_q;
                        q_d = q_q + WIDTH'(1);
                    end else begin
                        state_d = FIN;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous and covers every register, including the
        // latched divisor, so a mid-division reset leaves no stale operand behind.
        if (RST) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            div_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from the
            // same pre-edge values regardless of statement order.
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div_q   <= div_d;
            divz_q  <= divz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign DIVZ = divz_q;
    assign BUSY = (state_q == SUB);
    assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_divider_seq.sv
// Directed self-checking bench for divider_seq (WIDTH=8), including reset, divide by zero
// and the restart-during-SUB behaviour selected by DIV_ABORT_EN.
module tb_divider_seq;

    localparam int WIDTH = 8;
    localparam int LIMIT = 400;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s   = 1'b0;
    logic [WIDTH-1:0] a   = '0;
    logic [WIDTH-1:0] b   = '0;
    logic [WIDTH-1:0] q, r;
    logic             busy, done, divz;

    int errors = 0;
    int checks = 0;

    divider_seq #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst), .S(s), .A(a), .B(b),
        .Q(q), .R(r), .BUSY(busy), .DONE(done), .DIVZ(divz)
    );

    always #5 clk = ~clk;

    // Present operands, take edge k, then scramble A/B so later changes must be ignored.
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        s = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        s = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
    endtask

    // Counts edges after the start edge until DONE; lat = n means DONE after edge k+n.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (!done && lat < LIMIT) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q, r, busy, done, divz} !== '0) begin
            errors++;
            $display("FAIL reset_state: q=%0d r=%0d busy=%b done=%b divz=%b, want all 0", q, r, busy, done, divz);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, busy_n;
        start_op(8'd100, 8'd7);
        wait_done(lat, busy_n);
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL basic_latency: got %0d want 15", lat); end
        checks++;
        if (busy_n !== 15) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 15", busy_n); end
        checks++;
        if ({q, r, divz} !== {8'd14, 8'd2, 1'b0}) begin
            errors++; $display("FAIL basic_result: q=%0d r=%0d divz=%b want 14 2 0", q, r, divz);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, q, r} !== {1'b0, 1'b0, 8'd14, 8'd2}) begin
            errors++; $display("FAIL basic_done_pulse_hold: done=%b busy=%b q=%0d r=%0d", done, busy, q, r);
        end
    endtask

    task automatic test_small_and_fin_ignore();
        int lat, busy_n;
        start_op(8'd5, 8'd9);
        wait_done(lat, busy_n);
        checks++;
        if (lat !== 1 || busy_n !== 1) begin
            errors++; $display("FAIL small_latency: lat=%0d busy=%0d want 1 1", lat, busy_n);
        end
        checks++;
        if ({q, r} !== {8'd0, 8'd5}) begin errors++; $display("FAIL small_result: q=%0d r=%0d want 0 5", q, r); end
        // Start while in FIN must be dropped.
        start_op(8'd8, 8'd2);
        checks++;
        if ({busy, done, q, r} !== {1'b0, 1'b0, 8'd0, 8'd5}) begin
            errors++; $display("FAIL fin_ignore: busy=%b done=%b q=%0d r=%0d want 0 0 0 5", busy, done, q, r);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, q, r} !== {1'b0, 1'b0, 8'd0, 8'd5}) begin
            errors++; $display("FAIL idle_hold: busy=%b done=%b q=%0d r=%0d", busy, done, q, r);
        end
    endtask

    task automatic test_max();
        int lat, busy_n;
        start_op(8'd255, 8'd1);
        wait_done(lat, busy_n);
        checks++;
        if (lat !== 256 || busy_n !== 256) begin
            errors++; $display("FAIL max_latency: lat=%0d busy=%0d want 256 256", lat, busy_n);
        end
        checks++;
        if ({q, r} !== {8'd255, 8'd0}) begin errors++; $display("FAIL max_result: q=%0d r=%0d want 255 0", q, r); end
        @(posedge clk); #1;
    endtask

    task automatic test_divz();
        int lat, busy_n;
        start_op(8'd42, 8'd0);
        wait_done(lat, busy_n);
        checks++;
        if (lat !== 0 || busy_n !== 0) begin
            errors++; $display("FAIL divz_latency: lat=%0d busy=%0d want 0 0", lat, busy_n);
        end
        checks++;
        if ({q, r, divz} !== {8'd255, 8'd42, 1'b1}) begin
            errors++; $display("FAIL divz_result: q=%0d r=%0d divz=%b want 255 42 1", q, r, divz);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({divz, done} !== 2'b10) begin errors++; $display("FAIL divz_hold: divz=%b done=%b want 1 0", divz, done); end
        start_op(8'd9, 8'd3);
        checks++;
        if ({divz, busy} !== 2'b01) begin errors++; $display("FAIL divz_clear: divz=%b busy=%b want 0 1", divz, busy); end
        wait_done(lat, busy_n);
        checks++;
        if ({q, r} !== {8'd3, 8'd0} || lat !== 4) begin
            errors++; $display("FAIL divz_next: q=%0d r=%0d lat=%0d want 3 0 4", q, r, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, busy_n;
        int done_seen = 0;
        start_op(8'd200, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({q, r, busy, done, divz} !== '0) begin
            errors++;
            $display("FAIL reset_mid: q=%0d r=%0d busy=%b done=%b divz=%b want all 0", q, r, busy, done, divz);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) done_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL reset_no_done: active cycles=%0d want 0", done_seen); end
        start_op(8'd20, 8'd6);
        wait_done(lat, busy_n);
        checks++;
        if ({q, r} !== {8'd3, 8'd2} || lat !== 4) begin
            errors++; $display("FAIL reset_recover: q=%0d r=%0d lat=%0d want 3 2 4", q, r, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat, busy_n;
        start_op(8'd200, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        start_op(8'd10, 8'd4);
        wait_done(lat, busy_n);
`ifdef DIV_ABORT_EN
        checks++;
        if ({q, r} !== {8'd2, 8'd2} || lat !== 3) begin
            errors++; $display("FAIL abort_restart: q=%0d r=%0d lat=%0d want 2 2 3", q, r, lat);
        end
`else
        checks++;
        if ({q, r} !== {8'd66, 8'd2} || lat !== 64) begin
            errors++; $display("FAIL abort_ignored: q=%0d r=%0d lat=%0d want 66 2 64", q, r, lat);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_and_fin_ignore();
        test_max();
        test_divz();
        test_reset_mid();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
